// File: rtl/muldiv_if.sv
// muldiv_if: core-side op request, operand and result bus for muldiv_seq
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            done;
  logic            stall;
  modport master (output start, funct3, a, b, flush, input result, busy, done, stall);
  modport slave  (input start, funct3, a, b, flush, output result, busy, done, stall);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer that stalls the core until done.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish early once remaining multiplier bits are zero.
module muldiv_seq #(parameter int XLEN = 32) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave m
);
  localparam int CW = $clog2(XLEN + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, mc_q, mc_d, res_q, res_d;
  logic [2:0] f3_q, f3_d;
  logic sa_q, sa_d, sb_q, sb_d;
  logic sga, sgb, is_div, sc_zero, sc_ovf, nb;
  logic [XLEN-1:0] abs_a, abs_b, quo_f, rem_f;
  logic [XLEN:0] msum, rsh, diff;
  logic [2*XLEN-1:0] prod_f;
`ifdef MULDIV_EARLY_OUT_EN
  logic [2*XLEN-1:0] prod_sh;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    mc_d = mc_q;
    res_d = res_q;
    f3_d = f3_q;
    sa_d = sa_q;
    sb_d = sb_q;
    sga = !(m.funct3[0] && m.funct3 != 3'b001);
    sgb = sga && m.funct3 != 3'b010;
    abs_a = (sga && m.a[XLEN-1]) ? -m.a : m.a;
    abs_b = (sgb && m.b[XLEN-1]) ? -m.b : m.b;
    is_div = m.funct3[2];
    sc_zero = is_div && m.b == '0;
    sc_ovf = is_div && !m.funct3[0] && m.a == {1'b1, {(XLEN-1){1'b0}}} && m.b == '1;
    msum = {1'b0, hi_q} + {1'b0, mc_q & {XLEN{lo_q[0]}}};
    rsh = {hi_q, lo_q[XLEN-1]};
    diff = rsh - {1'b0, mc_q};
    // a wide partial remainder can never borrow; otherwise bit XLEN of the difference is the borrow
    nb = rsh[XLEN] | !diff[XLEN];
    prod_f = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_f = (sa_q ^ sb_q) ? -lo_q : lo_q;
    rem_f = sa_q ? -hi_q : hi_q;
`ifdef MULDIV_EARLY_OUT_EN
    prod_sh = {hi_q, lo_q} >> cnt_q;
`endif
    case (state_q)
      IDLE: if (m.start) begin
        f3_d = m.funct3;
        cnt_d = CW'(XLEN);
        hi_d = '0;
        lo_d = is_div ? abs_a : abs_b;
        mc_d = is_div ? abs_b : abs_a;
        sa_d = sga && m.a[XLEN-1];
        sb_d = sgb && m.b[XLEN-1];
        state_d = CALC;
        // shortcuts preload final quotient/remainder unsigned so FIX passes them through
        if (sc_zero || sc_ovf) begin
          lo_d = sc_zero ? '1 : m.a;
          hi_d = sc_zero ? m.a : '0;
          sa_d = 1'b0;
          sb_d = 1'b0;
          state_d = FIX;
        end
      end
      CALC: begin
        cnt_d = cnt_q - CW'(1);
        state_d = cnt_q == CW'(1) ? FIX : CALC;
        hi_d = f3_q[2] ? (nb ? diff[XLEN-1:0] : rsh[XLEN-1:0]) : msum[XLEN:1];
        lo_d = f3_q[2] ? {lo_q[XLEN-2:0], nb} : {msum[0], lo_q[XLEN-1:1]};
`ifdef MULDIV_EARLY_OUT_EN
        if (!f3_q[2] && (lo_q & ~({XLEN{1'b1}} << cnt_q)) == '0) begin
          {hi_d, lo_d} = prod_sh;
          state_d = FIX;
        end
`endif
      end
      FIX: begin
        res_d = f3_q[2] ? (f3_q[1] ? rem_f : quo_f)
                        : (f3_q[1:0] == 2'b00 ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN]);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (m.flush) begin
      state_d = IDLE;
      res_d = res_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      mc_q <= '0;
      res_q <= '0;
      f3_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      mc_q <= mc_d;
      res_q <= res_d;
      f3_q <= f3_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
    end
  end
  assign m.result = res_q;
  assign m.busy = state_q != IDLE;
  assign m.done = state_q == DONE;
  assign m.stall = (state_q == IDLE && m.start) || state_q == CALC || state_q == FIX;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed + random checks of muldiv_seq against a 64-bit reference model
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic reset;
  muldiv_if #(.XLEN(32)) bus ();
  muldiv_seq #(.XLEN(32)) dut (.clk(clk), .reset(reset), .m(bus));
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  logic [31:0] sb_q[$];
  logic [31:0] prev;
  logic seen;
  int n;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa = {{32{a[31]}}, a};
    logic signed [63:0] sb = {{32{b[31]}}, b};
    logic signed [63:0] ua = {32'b0, a};
    logic signed [63:0] ub = {32'b0, b};
    logic [63:0] p;
    logic ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] mb;
    int k = 0;
`endif
    if (f[2]) return (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 2 : 34;
`ifdef MULDIV_EARLY_OUT_EN
    mb = (!f[1] && b[31]) ? -b : b;
    for (int i = 0; i < 32; i++) if (mb[i]) k = i + 1;
    return (3 + k < 34) ? 3 + k : 34;
`else
    return 34;
`endif
  endfunction
  task automatic wait_done(output int cyc, output bit stall_ok);
    cyc = 0;
    stall_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (!bus.done) stall_ok &= bus.stall;
    end while (!bus.done && cyc < 60);
  endtask
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    bit s0, s1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = f;
    bus.a = a;
    bus.b = b;
    sb_q.push_back(model(f, a, b));
    #1 s0 = bus.stall;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.funct3 = 3'($urandom);
    wait_done(cyc, s1);
    check({tag, " result"}, bus.result, sb_q.pop_front());
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat(f, a, b)));
    check({tag, " stall"}, {29'b0, s0, s1, bus.stall}, 32'b110);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int cyc;
    bit sok;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.funct3 = 3'd0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset outputs", {bus.result[28:0], bus.busy, bus.done, bus.stall}, 32'd0);
    check("reset result", bus.result, 32'd0);
    run_op("mul 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op("mulh min*min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhu max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2);
    run_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("rem -7%2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("divu 100/7", 3'd5, 32'd100, 32'd7);
    run_op("remu 100%7", 3'd7, 32'd100, 32'd7);
    run_op("div by zero", 3'd4, 32'd5, 32'd0);
    run_op("rem by zero", 3'd6, 32'd5, 32'd0);
    run_op("divu by zero", 3'd5, 32'd9, 32'd0);
    run_op("div overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mul 9*1", 3'd0, 32'd9, 32'd1);
    run_op("mul by zero", 3'd0, 32'h1234_5678, 32'd0);
    for (int i = 0; i < 8; i++)
      run_op("random", 3'($urandom), $urandom, (i % 2) ? 32'($urandom_range(0, 300)) : $urandom);
    run_op("div -7/2 again", 3'd4, 32'hFFFF_FFF9, 32'd2);
    // flush mid-divide: no done, result retained
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.a = 32'd1000; bus.b = 32'd3;
    sb_q.push_back(model(3'd5, 32'd1000, 32'd3));
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(negedge clk);
    prev = bus.result;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    void'(sb_q.pop_front());
    check("flush busy", {31'b0, bus.busy}, 32'd0);
    check("flush result kept", bus.result, prev);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= bus.done; end
    check("flush no done", {31'b0, seen}, 32'd0);
    // flush wins over start in IDLE
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd5;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush beats start", {30'b0, bus.busy, bus.done}, 32'd0);
    // reset mid-divide: everything back to zero
    bus.start = 1'b1; bus.funct3 = 3'd4; bus.a = 32'd77; bus.b = 32'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset mid-op outputs", {bus.result[28:0], bus.busy, bus.done, bus.stall}, 32'd0);
    check("reset mid-op result", bus.result, 32'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= bus.done; end
    check("reset no done", {31'b0, seen}, 32'd0);
    // start held through DONE: second op accepted only once back in IDLE
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.a = 32'd7; bus.b = 32'd3;
    sb_q.push_back(model(3'd0, 32'd7, 32'd3));
    sb_q.push_back(model(3'd0, 32'd7, 32'd3));
    wait_done(cyc, sok);
    check("hold first result", bus.result, sb_q.pop_front());
    check("hold stall", {30'b0, sok, bus.stall}, 32'b10);
    check("hold first latency", 32'(cyc), 32'(exp_lat(3'd0, 32'd7, 32'd3)));
    @(negedge clk);
    check("hold idle restart", {29'b0, bus.busy, bus.done, bus.stall}, 32'b001);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(cyc, sok);
    check("hold second result", bus.result, sb_q.pop_front());
    check("hold second latency", 32'(cyc), 32'(exp_lat(3'd0, 32'd7, 32'd3)));
    @(negedge clk);
    check("idle after done", {29'b0, bus.busy, bus.done, bus.stall}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
